// File: rtl/mem_pkg.sv
// Shared width codes, controller state encoding and the request legality rule
// used by the data memory controller.
package mem_pkg;

    localparam logic [1:0] MEM_W_NONE = 2'd0;
    localparam logic [1:0] MEM_W_B    = 2'd1;
    localparam logic [1:0] MEM_W_H    = 2'd2;
    localparam logic [1:0] MEM_W_W    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP,
        ERR
    } mem_ctrl_state_t;

    // Illegal width, or a half/word access that straddles its natural boundary.
    function automatic logic bad_request(input logic [1:0] width, input logic [1:0] addr_lo);
        return (width == MEM_W_NONE)
            || (width == MEM_W_H && addr_lo[0])
            || (width == MEM_W_W && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Combinational load path: selects the addressed byte/half from the SRAM word
// and sign- or zero-extends it to 32 bits.
module load_data_aligner
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic        unsigned_load,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        data    = '0;
        case (width)
            MEM_W_B: data = {{24{~unsigned_load & shifted[7]}}, shifted[7:0]};
            MEM_W_H: data = {{16{~unsigned_load & shifted[15]}}, shifted[15:0]};
            MEM_W_W: data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_controller.sv
// Single-outstanding load/store controller in front of the data SRAM: alignment
// check, byte-lane generation, fixed read-latency wait and one-cycle response.
module data_memory_controller
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_width,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    mem_ctrl_state_t       state_q, state_d;
    logic                  cap_write;
    logic [1:0]            cap_width;
    logic                  cap_unsigned;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [2:0]            lat_cnt;
    logic                  accept;
    logic [3:0]            be_store;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [31:0]           load_data;

    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bad_request(req_width, req_addr[1:0]) ? ERR : ACCESS;
            ACCESS:  state_d = (cap_write || READ_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (lat_cnt == 3'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; capture registers are
    // reset too so outputs derived from them are never X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cap_write    <= 1'b0;
            cap_width    <= MEM_W_NONE;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            lat_cnt      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_write    <= req_write;
                cap_width    <= req_width;
                cap_unsigned <= req_unsigned;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
            end
            // WAIT counts down from READ_LATENCY-1 and hands over to RESP at 1.
            if (state_q == ACCESS)
                lat_cnt <= 3'(READ_LATENCY - 1);
            else if (state_q == WAIT)
                lat_cnt <= lat_cnt - 3'd1;
        end
    end

    always_comb begin
        be_store  = 4'b0000;
        wdata_rep = '0;
        case (cap_width)
            MEM_W_B: begin
                be_store  = 4'b0001 << cap_addr[1:0];
                wdata_rep = {4{cap_wdata[7:0]}};
            end
            MEM_W_H: begin
                be_store  = cap_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cap_wdata[15:0]}};
            end
            MEM_W_W: begin
                be_store  = 4'b1111;
                wdata_rep = cap_wdata;
            end
            default: begin
                be_store  = 4'b0000;
                wdata_rep = '0;
            end
        endcase
    end

    load_data_aligner u_aligner (
        .rdata         (mem_rdata),
        .addr          (cap_addr[1:0]),
        .width         (cap_width),
        .unsigned_load (cap_unsigned),
        .data          (load_data)
    );

    assign req_ready = (state_q == IDLE);
    assign mem_cs    = (state_q == ACCESS);
    assign mem_we    = mem_cs && cap_write;
    assign mem_be    = mem_cs ? (cap_write ? be_store : 4'b1111) : 4'b0000;
    assign mem_addr  = mem_cs ? cap_addr[ADDR_WIDTH-1:2] : '0;
    assign mem_wdata = mem_we ? wdata_rep : '0;
    assign rsp_valid = (state_q == RESP) || (state_q == ERR);
    assign rsp_error = (state_q == ERR);
    assign rsp_rdata = (state_q == RESP && !cap_write) ? load_data : '0;

endmodule

// File: tb/tb_data_memory_controller.sv
// Drives two controllers (read latency 1 and 3) with identical requests and checks
// every output, every cycle, against a timeline model derived from the access rules.
module tb_data_memory_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_rdata;

    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_error [2];
    logic        mem_cs    [2];
    logic        mem_we    [2];
    logic [31:0] rsp_rdata [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_be    [2];
    logic [29:0] mem_addr  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_memory_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready[0]), .req_write(req_write),
        .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_error(rsp_error[0]), .mem_cs(mem_cs[0]), .mem_we(mem_we[0]),
        .mem_be(mem_be[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata)
    );

    data_memory_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready[1]), .req_write(req_write),
        .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_error(rsp_error[1]), .mem_cs(mem_cs[1]), .mem_we(mem_we[1]),
        .mem_be(mem_be[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_err(input logic [1:0] w, input logic [31:0] a);
        return (w == 0) || (w == 2 && a[0] == 1'b1) || (w == 3 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] m_be(input bit write, input logic [1:0] w, input logic [31:0] a);
        if (!write) return 4'b1111;
        case (w)
            2'd1:    return 4'(1 << a[1:0]);
            2'd2:    return (a[1:0] >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] wd);
        case (w)
            2'd1:    return 32'(wd[7:0])  * 32'h0101_0101;
            2'd2:    return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] w, input logic [31:0] a,
                                           input bit uns, input logic [31:0] rd);
        logic [31:0] lane, v;
        lane = rd >> (8 * int'(a[1:0]));
        case (w)
            2'd1: begin
                v = lane & 32'hFF;
                if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            2'd2: begin
                v = lane & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Expected outputs of instance i, k cycles after the accepting edge.
    task automatic check_cycle(input string tag, input int i, input int k, input bit write,
                               input logic [1:0] w, input bit uns, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd);
        int    lat, rk;
        bit    err, acc, rsp, erc, busy;
        string p;
        lat  = (i == 0) ? 1 : 3;
        err  = m_err(w, a);
        rk   = write ? 2 : 1 + lat;
        acc  = !err && k == 1;
        rsp  = !err && k == rk;
        erc  = err && k == 1;
        busy = !err && k <= rk;
        p    = $sformatf("%s L%0d k%0d", tag, lat, k);
        check({p, " req_ready"}, 32'(req_ready[i]), 32'(!(busy || erc)));
        check({p, " mem_cs"},    32'(mem_cs[i]),    32'(acc));
        check({p, " mem_we"},    32'(mem_we[i]),    32'(acc && write));
        check({p, " mem_be"},    32'(mem_be[i]),    acc ? 32'(m_be(write, w, a)) : 32'd0);
        check({p, " mem_addr"},  32'(mem_addr[i]),  acc ? (a >> 2) : 32'd0);
        if (write || !acc)
            check({p, " mem_wdata"}, mem_wdata[i], (acc && write) ? m_wdata(w, wd) : 32'd0);
        check({p, " rsp_valid"}, 32'(rsp_valid[i]), 32'(rsp || erc));
        check({p, " rsp_error"}, 32'(rsp_error[i]), 32'(erc));
        check({p, " rsp_rdata"}, rsp_rdata[i], (rsp && !write) ? m_load(w, a, uns, rd) : 32'd0);
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, " req_ready"}, 32'(req_ready[i]), 32'd1);
            check({tag, " mem_cs"},    32'(mem_cs[i]),    32'd0);
            check({tag, " mem_we"},    32'(mem_we[i]),    32'd0);
            check({tag, " mem_be"},    32'(mem_be[i]),    32'd0);
            check({tag, " mem_addr"},  32'(mem_addr[i]),  32'd0);
            check({tag, " mem_wdata"}, mem_wdata[i],      32'd0);
            check({tag, " rsp_valid"}, 32'(rsp_valid[i]), 32'd0);
            check({tag, " rsp_error"}, 32'(rsp_error[i]), 32'd0);
            check({tag, " rsp_rdata"}, rsp_rdata[i],      32'd0);
        end
    endtask

    task automatic drive_req(input bit write, input logic [1:0] w, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = write;
        req_width    = w;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic scramble_req();
        req_write    = 1'($urandom);
        req_width    = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // One request, accepted at the next edge, then six observed cycles.
    task automatic run_txn(input string tag, input bit write, input logic [1:0] w, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
        @(negedge clk);
        drive_req(write, w, uns, a, wd);
        mem_rdata = rd;
        for (int i = 0; i < 2; i++) check({tag, " accept ready"}, 32'(req_ready[i]), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_req();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) check_cycle(tag, i, k, write, w, uns, a, wd, rd);
        end
    endtask

    initial begin
        logic [1:0]  w;
        logic [31:0] a;

        rst = 1'b1;
        req_valid = 1'b0;
        scramble_req();
        mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Directed: store replication, load extension, misalignment, latency.
        run_txn("sb_1003", 1'b1, 2'd1, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0);
        run_txn("lb_2",    1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 32'h80FF_7F01);
        run_txn("lbu_2",   1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h80FF_7F01);
        run_txn("lhu_2",   1'b0, 2'd2, 1'b1, 32'h0000_0002, 32'h0, 32'h80FF_7F01);
        run_txn("lh_2",    1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 32'h80FF_7F01);
        run_txn("lh_1",    1'b0, 2'd2, 1'b0, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF);
        run_txn("lw_6",    1'b0, 2'd3, 1'b0, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF);
        run_txn("lw_10",   1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        run_txn("sh_2",    1'b1, 2'd2, 1'b0, 32'h0000_0202, 32'hCAFE_1234, 32'h0);
        run_txn("sw_w0",   1'b1, 2'd0, 1'b0, 32'h0000_0040, 32'h1111_2222, 32'h0);
        for (int b = 0; b < 4; b++)
            run_txn($sformatf("sb_lane%0d", b), 1'b1, 2'd1, 1'b0, 32'h0000_0800 + 32'(b),
                    32'h0000_005A + 32'(b), 32'h0);

        // Reset while the latency-3 controller sits in WAIT drops the request.
        @(negedge clk);
        drive_req(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0);
        mem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check_cycle("rst_mid", i, k, 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
        end
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        check_idle("rst_hold");
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_idle($sformatf("rst_after%0d", k));
        end

        // req_valid held across two back-to-back stores.
        @(negedge clk);
        drive_req(1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'hA5A5_0F0F);
        @(posedge clk);
        #1;
        drive_req(1'b1, 2'd2, 1'b0, 32'h0000_0202, 32'h0000_BEEF);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check_cycle("b2b_first", i, k, 1'b1, 2'd3, 1'b0, 32'h100, 32'hA5A5_0F0F, 32'h0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check_cycle("b2b_second", i, k, 1'b1, 2'd2, 1'b0, 32'h202, 32'h0000_BEEF, 32'h0);
        end

        // Randomized traffic, mostly aligned.
        for (int n = 0; n < 40; n++) begin
            w = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (w == 2'd2) a[0] = 1'b0;
                if (w == 2'd3) a[1:0] = 2'b00;
            end
            run_txn($sformatf("rnd%0d", n), 1'($urandom), w, 1'($urandom), a, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
